ex_stage_reg: RTL
=================

Name: ex_stage_reg

Overview:
- ID/EX boundary register for the conditional-execution path. Latches decode-stage control into EX (cond_e, branch_e, flags_write_e, payload) and holds the architectural NZCV flags register.
- Feeds the downstream condition evaluator: cond_e, branch_e, flags_write_e and flags_q go in; flags_next and cond_ex come back.
- Detects the flag read-after-write hazard for branches and sequences the pipeline flush after a taken branch.

Parameters:
- PAYLOAD_W, 64: width of the opaque EX payload (operands, ALU control, destination register); passed through untouched.
- FLUSH_CYCLES, 2: number of EX bubbles inserted after a taken branch; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  global stall: freeze all state
- flush_i  in  1  external flush: load a bubble into EX
- valid_d  in  1  decode slot holds a real instruction
- cond_d  in  4  condition code of the decode instruction
- branch_d  in  1  decode instruction is a branch
- flags_write_d  in  2  [1]=update N,Z; [0]=update C,V
- payload_d  in  PAYLOAD_W  remaining decode fields
- flags_next  in  4  {N,Z,C,V} computed by the condition evaluator
- cond_ex  in  1  condition of the EX instruction passed
- valid_e  out  1  EX holds a real instruction
- cond_e  out  4  to the evaluator
- branch_e  out  1  to the evaluator
- flags_write_e  out  2  to the evaluator; forced 0 when valid_e=0
- payload_e  out  PAYLOAD_W  to the EX datapath
- flags_q  out  4  architectural {N,Z,C,V}; drives the evaluator Flags input
- flag_stall_d  out  1  combinational; stall fetch and decode one cycle
- branch_taken  out  1  combinational; redirect the PC
- flush_fd  out  1  combinational; squash the fetch and decode slots

Behaviour:
- Reset (async, rst_n=0):
  - valid_e=0, cond_e=4'b0000 (Always), branch_e=0, flags_write_e=0, payload_e=0.
  - flags_q=0, flush counter=0, FSM=RUN.
  - Release is synchronous to the next edge. Reset mid-flush aborts the flush.
- Bubble definition: valid_e=0, cond_e=0, branch_e=0, flags_write_e=0. payload_e holds its previous value.
- branch_taken = valid_e & branch_e & cond_ex & ~stall_i.
- flag_stall_d = valid_d & branch_d & valid_e & (|flags_write_e) & ~branch_taken & (state==RUN).
  - The evaluator reads registered flags, so a branch directly behind a flag-setting instruction waits one cycle.
- FSM states:
  - RUN: cnt==0.
  - FLUSH: cnt>0. cnt is 3 bits.
- Per-edge priority, highest first:
  1. stall_i=1: hold every register, flags_q and cnt.
  2. flush_i=1: EX<=bubble; cnt<=0; FSM->RUN.
  3. branch_taken: EX<=bubble; cnt<=FLUSH_CYCLES-1; FSM->FLUSH if FLUSH_CYCLES>1, else RUN.
  4. FSM=FLUSH: EX<=bubble; cnt<=cnt-1; FSM->RUN when cnt reaches 0.
  5. flag_stall_d: EX<=bubble. Decode holds externally.
  6. Otherwise: EX<=decode fields, valid_e<=valid_d. Control fields are zeroed if valid_d=0.
- flush_fd = branch_taken | (state==FLUSH).
- Flags register:
  - When ~stall_i & valid_e: flags_q<=flags_next.
  - Otherwise flags_q holds.
  - Rules 2–5 do not inhibit the flags update of the instruction currently leaving EX.
- Latency: decode to EX is 1 cycle. A flag write is visible on flags_q 1 cycle after EX.
- Simultaneous events:
  - taken + flag hazard: taken wins; no stall.
  - flush_i + taken: flush_i wins for EX and cnt. branch_taken still asserts, so the PC redirect still happens.
  - stall_i + taken: branch_taken=0 until the stall releases.

Decomposition:
- Shared package cond_pkg:
  - Condition-code constants COND_AL=0, COND_EQ=1 … COND_LS=14.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef flush_state_t {RUN, FLUSH}.
  - typedef nzcv_t logic[3:0].
- Sub-module nzcv_reg: 4-bit async-reset register with load enable. Instantiated once.

Test Plan:
- Reset mid-flush: assert rst_n=0 during FLUSH -> all outputs 0 immediately; cnt=0; after release one valid decode load gives valid_e=1.
- Pass-through: valid_d=1, cond_d=4'h1, flags_write_d=2'b11, payload_d=64'hDEAD_BEEF, stall_i=0 -> next cycle valid_e=1, cond_e=1, flags_write_e=3, payload_e=64'hDEAD_BEEF; with flags_next=4'b0100, flags_q=4'b0100 one cycle later.
- Flag hazard: EX flags_write_e=2'b10, decode branch_d=1 -> flag_stall_d=1 for exactly one cycle; EX gets a bubble; the branch enters EX on the following edge.
- Taken branch, FLUSH_CYCLES=2: valid_e=1, branch_e=1, cond_ex=1 -> branch_taken=1; flush_fd=1 for 2 cycles; valid_e=0 for 2 cycles; normal loads resume on the 3rd edge.
- Not-taken branch: cond_ex=0 -> branch_taken=0, flush_fd=0; next decode instruction enters EX with no bubble.
- Stall priority: stall_i=1 with taken conditions and flags_next=4'hF -> branch_taken=0; flags_q, cnt and EX registers unchanged until stall_i drops; then branch_taken=1.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution path.
// Holds the condition codes, the NZCV bit positions and the flush FSM state type.
package cond_pkg;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_CS = 4'd3;
    localparam logic [3:0] COND_CC = 4'd4;
    localparam logic [3:0] COND_MI = 4'd5;
    localparam logic [3:0] COND_PL = 4'd6;
    localparam logic [3:0] COND_VS = 4'd7;
    localparam logic [3:0] COND_VC = 4'd8;
    localparam logic [3:0] COND_GE = 4'd9;
    localparam logic [3:0] COND_LT = 4'd10;
    localparam logic [3:0] COND_GT = 4'd11;
    localparam logic [3:0] COND_LE = 4'd12;
    localparam logic [3:0] COND_HI = 4'd13;
    localparam logic [3:0] COND_LS = 4'd14;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

    typedef logic [3:0] nzcv_t;

endpackage

// File: rtl/nzcv_reg.sv
// Architectural NZCV flags register: 4 bits, async active-low reset, load enable.
module nzcv_reg
    import cond_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  nzcv_t d,
    output nzcv_t q
);

    nzcv_t flags_q, flags_d;

    always_comb begin
        flags_d = en ? d : flags_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else        flags_q <= flags_d;
    end

    assign q = flags_q;

endmodule

// File: rtl/ex_stage_reg.sv
// ID/EX boundary register for the conditional-execution path: latches decode control,
// owns the NZCV flags, detects the branch flag hazard and sequences post-branch flushes.
module ex_stage_reg
    import cond_pkg::*;
#(
    parameter int PAYLOAD_W    = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 valid_d,
    input  logic [3:0]           cond_d,
    input  logic                 branch_d,
    input  logic [1:0]           flags_write_d,
    input  logic [PAYLOAD_W-1:0] payload_d,
    input  logic [3:0]           flags_next,
    input  logic                 cond_ex,
    output logic                 valid_e,
    output logic [3:0]           cond_e,
    output logic                 branch_e,
    output logic [1:0]           flags_write_e,
    output logic [PAYLOAD_W-1:0] payload_e,
    output logic [3:0]           flags_q,
    output logic                 flag_stall_d,
    output logic                 branch_taken,
    output logic                 flush_fd
);

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    logic                 valid_e_q, valid_e_d;
    logic [3:0]           cond_e_q, cond_e_d;
    logic                 branch_e_q, branch_e_d;
    logic [1:0]           fw_e_q, fw_e_d;
    logic [PAYLOAD_W-1:0] payload_e_q, payload_e_d;
    flush_state_t         state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 bubble;

    always_comb begin
        branch_taken = valid_e_q & branch_e_q & cond_ex & ~stall_i;
        flag_stall_d = valid_d & branch_d & valid_e_q & (|fw_e_q) & ~branch_taken
                     & (state_q == RUN);
        flush_fd     = branch_taken | (state_q == FLUSH);

        valid_e_d   = valid_e_q;
        cond_e_d    = cond_e_q;
        branch_e_d  = branch_e_q;
        fw_e_d      = fw_e_q;
        payload_e_d = payload_e_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bubble      = 1'b0;

        if (stall_i) begin
            bubble = 1'b0;
        end else if (flush_i) begin
            bubble  = 1'b1;
            cnt_d   = '0;
            state_d = RUN;
        end else if (branch_taken) begin
            bubble  = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (state_q == FLUSH) begin
            bubble  = 1'b1;
            cnt_d   = cnt_q - 3'd1;
            state_d = (cnt_q == 3'd1) ? RUN : FLUSH;
        end else if (flag_stall_d) begin
            bubble = 1'b1;
        end else begin
            // Control of an empty decode slot is zeroed; the payload is opaque and loads anyway.
            valid_e_d   = valid_d;
            cond_e_d    = valid_d ? cond_d : COND_AL;
            branch_e_d  = valid_d & branch_d;
            fw_e_d      = valid_d ? flags_write_d : 2'b00;
            payload_e_d = payload_d;
        end

        if (bubble) begin
            valid_e_d  = 1'b0;
            cond_e_d   = COND_AL;
            branch_e_d = 1'b0;
            fw_e_d     = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e_q   <= 1'b0;
            cond_e_q    <= COND_AL;
            branch_e_q  <= 1'b0;
            fw_e_q      <= 2'b00;
            payload_e_q <= '0;
            state_q     <= RUN;
            cnt_q       <= '0;
        end else begin
            valid_e_q   <= valid_e_d;
            cond_e_q    <= cond_e_d;
            branch_e_q  <= branch_e_d;
            fw_e_q      <= fw_e_d;
            payload_e_q <= payload_e_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
        end
    end

    // The instruction leaving EX commits its flags even when EX is refilled with a bubble.
    nzcv_reg u_nzcv (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~stall_i & valid_e_q),
        .d     (flags_next),
        .q     (flags_q)
    );

    assign valid_e       = valid_e_q;
    assign cond_e        = cond_e_q;
    assign branch_e      = branch_e_q;
    assign flags_write_e = fw_e_q;
    assign payload_e     = payload_e_q;

endmodule
